// File: rtl/serial_word_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_deserializer_if
// Description : Bundle of signals for serial_word_deserializer. It carries the
//               serial bit stream, the parallel valid/ready word output and the
//               status flags.
//               master : serial source / word consumer side (drives the stream
//                        and out_ready)
//               slave  : the deserializer itself
// Signals     : ser_in, ser_valid, frame_start   - serial bit, strobe, frame mark
//               data_out[WIDTH], out_valid      - held word and its valid flag
//               out_ready                       - consumer accepts data_out
//               busy, frame_err, overrun        - status
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_word_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             ser_in;
  logic             ser_valid;
  logic             frame_start;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    output ser_in, ser_valid, frame_start, out_ready,
    input  data_out, out_valid, busy, frame_err, overrun
  );

  modport slave (
    input  ser_in, ser_valid, frame_start, out_ready,
    output data_out, out_valid, busy, frame_err, overrun
  );
endinterface
`default_nettype wire

// File: rtl/serial_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_deserializer
// Description : Serial-in, parallel-out word receiver. It assembles WIDTH-bit
//               words from a framed bit stream with one bit per ser_valid
//               strobe. Each completed word is held in a one-entry register
//               that has a valid/ready handshake. The block flags framing
//               restarts (frame_err pulse) and dropped words (sticky overrun).
// Ports       : clk  - clock, all logic on posedge
//               rst  - synchronous active-high reset
//               bus  - serial_word_deserializer_if.slave (stream in, word out,
//                      status flags)
// Parameters  : WIDTH     - word width, must be >= 2
//               MSB_FIRST - 1: first bit lands in data_out[WIDTH-1]
//                           0: first bit lands in data_out[0]
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire                          clk,
  input  wire                          rst,
  serial_word_deserializer_if.slave    bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_ONE  = CW'(1);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_first_load;
  logic [WIDTH-1:0] r_data;
  logic             r_out_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic w_start;
  logic w_accept;
  logic w_restart;
  logic w_complete;
  logic w_load;

  // A framed bit always starts a new word. In SHIFT it also abandons the
  // partial word.
  assign w_start    = bus.ser_valid & bus.frame_start;
  assign w_accept   = (r_state == c_SHIFT) & bus.ser_valid & ~bus.frame_start;
  assign w_restart  = (r_state == c_SHIFT) & w_start;
  assign w_complete = w_accept & (r_cnt == c_LAST);
  // The holding register takes the new word when it is empty or is being
  // drained on this same edge.
  assign w_load     = w_complete & (~r_out_valid | bus.out_ready);

  // Bit ordering. A word always completes after WIDTH-1 shifts, so the first
  // bit is loaded at the end opposite its final position. The bit that
  // shifts out on completion is never needed.
  generate
    if (MSB_FIRST) begin : g_msb_first
      logic w_unused_shreg_bit;
      assign w_shift_next       = {r_shreg[WIDTH-2:0], bus.ser_in};
      assign w_first_load       = {{(WIDTH-1){1'b0}}, bus.ser_in};
      assign w_unused_shreg_bit = r_shreg[WIDTH-1];
    end else begin : g_lsb_first
      logic w_unused_shreg_bit;
      assign w_shift_next       = {bus.ser_in, r_shreg[WIDTH-1:1]};
      assign w_first_load       = {bus.ser_in, {(WIDTH-1){1'b0}}};
      assign w_unused_shreg_bit = r_shreg[0];
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_start) begin
          w_state_next = c_SHIFT;
        end
      end
      c_SHIFT: begin
        if (w_restart) begin
          w_state_next = c_SHIFT;
        end else if (w_complete) begin
          w_state_next = c_IDLE;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // FSM / datapath outputs
  always_comb begin
    bus.busy      = (r_state == c_SHIFT);
    bus.data_out  = r_data;
    bus.out_valid = r_out_valid;
    bus.frame_err = r_frame_err;
    bus.overrun   = r_overrun;
  end

  // Shift register, bit counter, holding register and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_start) begin
        r_shreg <= w_first_load;
        r_cnt   <= c_ONE;
      end else if (w_accept) begin
        r_shreg <= w_shift_next;
        r_cnt   <= w_complete ? '0 : (r_cnt + c_ONE);
      end

      r_frame_err <= w_restart;

      if (w_complete) begin
        if (w_load) begin
          r_data      <= w_shift_next;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun   <= 1'b1;
        end
      end else if (r_out_valid & bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
